gauss_filter_param: RTL and testbench
=====================================

GAUSS_FILTER_PARAM -- requirements
Module: gauss_filter_param

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per row, minimum 3.
REQ-002 SHALL have parameter IMG_H, default 256, rows per frame, minimum 3.
REQ-003 SHALL have parameter CH, default 3, channels per pixel.
REQ-004 SHALL have parameter CW, default 8, bits per channel; channel k occupies data bits [k*CW +: CW], channel 0 at the LSBs.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_mode, input, 1 bit: 0 = 3x3 Gaussian filter, 1 = bypass.
REQ-008 SHALL have port i_rgb_vld, input, 1 bit: input pixel valid.
REQ-009 SHALL have port i_rgb_data, input, CH*CW bits: input pixel, raster order.
REQ-010 SHALL have port i_rgb_busy, output, 1 bit: the block cannot accept input this cycle.
REQ-011 SHALL have port o_rgb_busy, input, 1 bit: downstream cannot accept output.
REQ-012 SHALL have port o_rgb_vld, output, 1 bit: output pixel valid.
REQ-013 SHALL have port o_rgb_data, output, CH*CW bits: output pixel.
REQ-014 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse when the last output of a frame transfers.

Function
REQ-015 An input transfer SHALL occur on a rising edge where i_rgb_vld=1 and i_rgb_busy=0.
REQ-016 An output transfer SHALL occur on a rising edge where o_rgb_vld=1 and o_rgb_busy=0.
REQ-017 Handshake rules:
- i_rgb_busy SHALL equal o_rgb_vld AND o_rgb_busy, combinationally.
- Input is therefore accepted in the same cycle that a pending output drains.
REQ-018 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1):
- both advance on every input transfer;
- col wraps to 0 and row increments;
- after (IMG_W-1, IMG_H-1) both wrap to 0 (new frame).
REQ-019 i_mode SHALL be sampled only on the input transfer at col=0,row=0 and held for the whole frame; mid-frame changes are ignored.
REQ-020 The block SHALL hold two line buffers of IMG_W pixels each and a 3x3 window of CH*CW-bit registers, updated on every input transfer in both modes.
REQ-021 In filter mode, an input transfer at (row,col) with row>=2 and col>=2 SHALL produce the output for center (row-1,col-1); border pixels produce no output, giving (IMG_W-2)*(IMG_H-2) outputs per frame.
REQ-022 Per channel the output SHALL be (sum + 8) >> 4, where sum is the window weighted by kernel [1 2 1; 2 4 2; 1 2 1]:
- computed at CW+4 bits;
- the result fits in CW bits, so no saturation is required.
REQ-023 In bypass mode every input transfer SHALL produce an output equal to i_rgb_data, giving IMG_W*IMG_H outputs per frame.
REQ-024 Latency: o_rgb_vld and o_rgb_data SHALL be registered and assert on the edge following the producing input transfer; the data is computed from the window including that input.
REQ-025 While o_rgb_vld=1 and o_rgb_busy=1, o_rgb_data and o_rgb_vld SHALL hold stable.
REQ-026 o_rgb_vld SHALL clear after an output transfer unless a new output is produced on the same edge.
REQ-027 o_frame_done SHALL pulse for one cycle on the edge after the output transfer of the last output of a frame:
- center (IMG_H-2, IMG_W-2) in filter mode;
- pixel (IMG_H-1, IMG_W-1) in bypass mode.

Reset
REQ-028 While i_rst=0, the block SHALL asynchronously drive o_rgb_vld=0, o_rgb_data=0 and o_frame_done=0, and clear col, row, the window and the latched mode (to 0).
REQ-029 Line buffer contents SHALL need no reset; outputs never depend on stale line data, because of REQ-021.
REQ-030 After a reset asserted mid-frame, the next accepted pixel SHALL be treated as (0,0) of a new frame.

Verification (IMG_W=IMG_H=4, CH=3, CW=8)
REQ-031 Constant frame:
- stimulus: mode 0, all 16 pixels 0x404040;
- response: exactly 4 outputs, each 0x404040, then o_frame_done pulses once.
REQ-032 Impulse:
- stimulus: mode 0, pixel (1,1)=0x0000FF, all others 0;
- response: output centers (1,1),(1,2),(2,1),(2,2) equal 0x000040, 0x000020, 0x000020, 0x000010 respectively.
REQ-033 Bypass:
- stimulus: mode 1, pixels 0x000000..0x00000F;
- response: 16 outputs identical in order; o_frame_done follows the 16th transfer.
REQ-034 Backpressure:
- stimulus: o_rgb_busy=1 for 5 cycles while an output is pending;
- response: o_rgb_data stable, i_rgb_busy=1, no pixel lost or duplicated; output counts per REQ-031 still met.
REQ-035 Reset mid-frame:
- stimulus: i_rst=0 after 7 input pixels, then release and send a full constant frame;
- response: o_rgb_vld=0 during reset, then results identical to REQ-031.
REQ-036 Mid-frame mode change:
- stimulus: i_mode toggles 0->1 at pixel 5;
- response: the frame completes in filter mode with 4 outputs; the next frame runs in bypass mode with 16 outputs.

Source files
------------

// File: rtl/gauss_filter_param.sv
// Streaming 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16, rounded) with per-frame bypass mode.
// Two line buffers feed a sliding window; one registered output stage with valid/busy handshake.
module gauss_filter_param #(
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 256,
    parameter int unsigned CH    = 3,
    parameter int unsigned CW    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mode,
    input  logic             i_rgb_vld,
    input  logic [CH*CW-1:0] i_rgb_data,
    output logic             i_rgb_busy,
    input  logic             o_rgb_busy,
    output logic             o_rgb_vld,
    output logic [CH*CW-1:0] o_rgb_data,
    output logic             o_frame_done
);

    localparam int unsigned PW    = CH * CW;
    localparam int unsigned SW    = CW + 4;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             mode_q, mode_d;
    logic             vld_q, vld_d;
    logic [PW-1:0]    data_q, data_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    // Window: two registered columns (older, newer) per row; the live column completes the 3x3.
    logic [PW-1:0] win_q [3][2];
    logic [PW-1:0] win_d [3][2];
    logic [PW-1:0] lb0_q [IMG_W];
    logic [PW-1:0] lb1_q [IMG_W];
    logic [PW-1:0] new_col [3];
    logic [PW-1:0] filt;

    logic accept, out_xfer, first_px, col_last, row_last, mode_eff, produce;

    assign i_rgb_busy = vld_q & o_rgb_busy;
    assign accept     = i_rgb_vld & ~i_rgb_busy;
    assign out_xfer   = vld_q & ~o_rgb_busy;
    assign first_px   = (col_q == '0) && (row_q == '0);
    assign col_last   = (col_q == COL_W'(IMG_W - 1));
    assign row_last   = (row_q == ROW_W'(IMG_H - 1));
    assign mode_eff   = first_px ? i_mode : mode_q;
    assign produce    = accept & (mode_eff | ((row_q >= ROW_W'(2)) & (col_q >= COL_W'(2))));

    assign new_col[0] = lb1_q[col_q];
    assign new_col[1] = lb0_q[col_q];
    assign new_col[2] = i_rgb_data;

    function automatic logic [SW-1:0] px(input logic [PW-1:0] p, input int unsigned ch);
        return SW'(p[ch*CW +: CW]);
    endfunction

    // Weighted sum per channel, rounded by +8 before the divide by 16.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SW-1:0] sum;
        assign sum = px(win_q[0][0], g)        + (px(win_q[0][1], g) << 1) + px(new_col[0], g)
                   + (px(win_q[1][0], g) << 1) + (px(win_q[1][1], g) << 2) + (px(new_col[1], g) << 1)
                   + px(win_q[2][0], g)        + (px(win_q[2][1], g) << 1) + px(new_col[2], g)
                   + SW'(8);
        assign filt[g*CW +: CW] = sum[SW-1:4];
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = mode_q;
        win_d  = win_q;
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        done_d = out_xfer & last_q;
        if (out_xfer) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
        if (accept) begin
            if (first_px) begin
                mode_d = i_mode;
            end
            col_d = col_last ? '0 : col_q + COL_W'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = new_col[r];
            end
            if (produce) begin
                vld_d  = 1'b1;
                data_d = mode_eff ? i_rgb_data : filt;
                last_d = row_last & col_last;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= 1'b0;
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            mode_q <= mode_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            done_q <= done_d;
            win_q  <= win_d;
        end
    end

    // Line buffers: lb0 holds the previous row, lb1 the row before it.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= i_rgb_data;
        end
    end

    assign o_rgb_vld    = vld_q;
    assign o_rgb_data   = data_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_gauss_filter_param.sv
// Directed bench for gauss_filter_param (4x4, 3x8-bit): frame-level reference model,
// per-cycle output/handshake/frame-done checker, backpressure and reset scenarios.
module tb_gauss_filter_param;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int CH  = 3;
    localparam int CW  = 8;
    localparam int PW  = CH * CW;
    localparam int NPX = W * H;

    typedef logic [PW-1:0] frame_t [NPX];
    typedef struct packed {
        logic [PW-1:0] d;
        logic          last;
    } exp_t;

    logic          i_clk, i_rst, i_mode, i_rgb_vld, i_rgb_busy;
    logic          o_rgb_busy, o_rgb_vld, o_frame_done;
    logic [PW-1:0] i_rgb_data, o_rgb_data;

    gauss_filter_param #(.IMG_W(W), .IMG_H(H), .CH(CH), .CW(CW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_mode      (i_mode),
        .i_rgb_vld   (i_rgb_vld),
        .i_rgb_data  (i_rgb_data),
        .i_rgb_busy  (i_rgb_busy),
        .o_rgb_busy  (o_rgb_busy),
        .o_rgb_vld   (o_rgb_vld),
        .o_rgb_data  (o_rgb_data),
        .o_frame_done(o_frame_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          exp_q[$];
    logic [PW-1:0] model_out[$];
    logic          bp_arm  = 1'b0;
    int            bp_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: whole-frame convolution on the image array, border centers skipped.
    task automatic model_frame(input frame_t img, input logic mode);
        logic [PW-1:0] p, o;
        int            s, wgt;
        model_out.delete();
        if (mode) begin
            for (int i = 0; i < NPX; i++) model_out.push_back(img[i]);
        end else begin
            for (int r = 1; r < H - 1; r++) begin
                for (int c = 1; c < W - 1; c++) begin
                    o = '0;
                    for (int ch = 0; ch < CH; ch++) begin
                        s = 0;
                        for (int dr = -1; dr <= 1; dr++) begin
                            for (int dc = -1; dc <= 1; dc++) begin
                                wgt = ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
                                p   = img[(r + dr) * W + c + dc];
                                s  += wgt * int'(p[ch*CW +: CW]);
                            end
                        end
                        o[ch*CW +: CW] = CW'((s + 8) / 16);
                    end
                    model_out.push_back(o);
                end
            end
        end
    endtask

    task automatic enqueue_frame(input frame_t img, input logic mode);
        exp_t e;
        model_frame(img, mode);
        for (int i = 0; i < model_out.size(); i++) begin
            e.d    = model_out[i];
            e.last = (i == model_out.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_px(input logic [PW-1:0] d, input logic m);
        int n = 0;
        i_rgb_vld  = 1'b1;
        i_rgb_data = d;
        i_mode     = m;
        forever begin
            @(negedge i_clk);
            if (!i_rgb_busy) break;
            n++;
            if (n > 200) begin
                check("in_accept_timeout", 32'(i_rgb_busy), 32'd0);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_rgb_vld = 1'b0;
    endtask

    task automatic send_frame(input frame_t img, input logic mode0, input int toggle_at, input int count);
        logic m;
        for (int i = 0; i < count; i++) begin
            m = (toggle_at >= 0 && i >= toggle_at) ? ~mode0 : mode0;
            send_px(img[i], m);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge i_clk);
        repeat (3) @(posedge i_clk);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Downstream stall: when armed, hold busy for 5 cycles once an output is pending.
    initial begin
        o_rgb_busy = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (bp_arm && o_rgb_vld) begin
                bp_arm  = 1'b0;
                bp_left = 5;
            end
            if (bp_left > 0) begin
                o_rgb_busy = 1'b1;
                bp_left--;
            end else begin
                o_rgb_busy = 1'b0;
            end
        end
    end

    // Per-cycle checker: reset values, handshake, hold-under-stall, output order, frame-done.
    logic          exp_done   = 1'b0;
    logic          stall_prev = 1'b0;
    logic [PW-1:0] stall_data = '0;
    exp_t          e_mon;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("reset_outputs", {7'd0, o_rgb_vld, o_rgb_data}, 32'd0);
            check("reset_done", 32'(o_frame_done), 32'd0);
            exp_done   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("frame_done", 32'(o_frame_done), 32'(exp_done));
            exp_done = 1'b0;
            check("in_busy", 32'(i_rgb_busy), 32'(o_rgb_vld & o_rgb_busy));
            if (stall_prev) begin
                check("stall_vld_hold", 32'(o_rgb_vld), 32'd1);
                check("stall_data_hold", 32'(o_rgb_data), 32'(stall_data));
            end
            if (o_rgb_vld && !o_rgb_busy) begin
                check("out_expected_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    check("out_data", 32'(o_rgb_data), 32'(e_mon.d));
                    exp_done = e_mon.last;
                end
            end
            stall_prev = o_rgb_vld && o_rgb_busy;
            stall_data = o_rgb_data;
        end
    end

    frame_t const_f, imp_f, byp_f, ramp_f;

    initial begin
        i_rst      = 1'b0;
        i_mode     = 1'b0;
        i_rgb_vld  = 1'b0;
        i_rgb_data = '0;
        for (int i = 0; i < NPX; i++) begin
            const_f[i] = 24'h404040;
            imp_f[i]   = '0;
            byp_f[i]   = PW'(i);
            ramp_f[i]  = {8'(i * 16), 8'(255 - i * 10), 8'(i * i)};
        end
        imp_f[5] = 24'h0000FF;

        // Hand-computed values pin the reference model.
        model_frame(const_f, 1'b0);
        check("model_const_count", 32'(model_out.size()), 32'd4);
        for (int i = 0; i < model_out.size(); i++) check("model_const_val", 32'(model_out[i]), 32'h404040);
        model_frame(imp_f, 1'b0);
        check("model_imp_11", 32'(model_out[0]), 32'h000040);
        check("model_imp_12", 32'(model_out[1]), 32'h000020);
        check("model_imp_21", 32'(model_out[2]), 32'h000020);
        check("model_imp_22", 32'(model_out[3]), 32'h000010);
        model_frame(byp_f, 1'b1);
        check("model_byp_count", 32'(model_out.size()), 32'd16);
        check("model_byp_last", 32'(model_out[15]), 32'h00000F);

        repeat (3) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;

        enqueue_frame(const_f, 1'b0);
        send_frame(const_f, 1'b0, -1, NPX);
        drain();

        enqueue_frame(imp_f, 1'b0);
        send_frame(imp_f, 1'b0, -1, NPX);
        drain();

        enqueue_frame(byp_f, 1'b1);
        send_frame(byp_f, 1'b1, -1, NPX);
        drain();

        bp_arm = 1'b1;
        enqueue_frame(const_f, 1'b0);
        send_frame(const_f, 1'b0, -1, NPX);
        drain();

        bp_arm = 1'b1;
        enqueue_frame(ramp_f, 1'b0);
        send_frame(ramp_f, 1'b0, -1, NPX);
        drain();

        // Reset after 7 pixels; the next pixel must start a fresh frame.
        send_frame(ramp_f, 1'b0, -1, 7);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        enqueue_frame(const_f, 1'b0);
        send_frame(const_f, 1'b0, -1, NPX);
        drain();

        // Mode flips at pixel 5: this frame stays filtered, the next one is bypass.
        enqueue_frame(ramp_f, 1'b0);
        send_frame(ramp_f, 1'b0, 5, NPX);
        bp_arm = 1'b1;
        enqueue_frame(ramp_f, 1'b1);
        send_frame(ramp_f, 1'b1, -1, NPX);
        drain();

        repeat (3) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
